// File: rtl/hex_letter_sequencer_if.sv
// hex_letter_sequencer_if: board-side bundle for the HEX0 letter sequencer.
// Carries the slide switches in and the HEX0 / LEDG displays out.
// The master side is whoever drives the switches; the slave is the sequencer.
interface hex_letter_sequencer_if;
  logic [9:0] SW;
  logic [7:0] HEX0;
  logic [7:0] LEDG;

  modport master (
    output SW,
    input  HEX0,
    input  LEDG
  );

  modport slave (
    input  SW,
    output HEX0,
    output LEDG
  );
endinterface

// File: rtl/hex_letter_sequencer.sv
// hex_letter_sequencer: drives HEX0 with A / B / C / blank.
// In manual mode the switch-selected letter is shown directly. In auto mode
// the letters step A->B->C (or reverse) with a dwell of L base ticks, where a
// base tick occurs every BASE_DIV clocks.
// Optional build macro SEQ_BLINK_EN: when defined, a paused auto sequence
// (L = 0) blinks the held letter against blank on every base tick.
module hex_letter_sequencer #(
  parameter int BASE_DIV = 5000000
) (
  input  logic                   CLOCK_50,
  input  logic                   KEY0,
  hex_letter_sequencer_if.slave  bus
);

  localparam int            PW         = $clog2(BASE_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(BASE_DIV - 1);

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2,
    SHOW_C = 2'd3
  } state_t;

  // Active-low segment pattern for each letter state.
  function automatic logic [7:0] seg_of(input state_t s);
    logic [7:0] seg;
    case (s)
      BLANK:   seg = 8'hFF;
      SHOW_A:  seg = 8'h08;
      SHOW_B:  seg = 8'h03;
      SHOW_C:  seg = 8'h46;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Next letter in the auto sequence; anything unexpected restarts at A.
  function automatic state_t next_letter(input state_t s, input logic rev);
    state_t n;
    case (s)
      SHOW_A:  n = rev ? SHOW_C : SHOW_B;
      SHOW_B:  n = rev ? SHOW_A : SHOW_C;
      SHOW_C:  n = rev ? SHOW_B : SHOW_A;
      default: n = SHOW_A;
    endcase
    return n;
  endfunction

  logic [9:0]    sw_meta_r;
  logic [9:0]    sw_sync_r;
  state_t        state_r;
  logic          auto_r;
  logic [PW-1:0] presc_r;
  logic [3:0]    dwell_r;
  logic [7:0]    hex_r;
  logic [7:0]    ledg_r;

  logic          auto_s;
  logic          rev_s;
  logic [3:0]    limit_s;
  logic [1:0]    sel_s;
  logic [1:0]    sw_unused_s;
  logic          tick_s;
  state_t        state_nxt_s;
  logic [PW-1:0] presc_nxt_s;
  logic [3:0]    dwell_nxt_s;
  logic          tick_nxt_s;
  logic [7:0]    hex_nxt_s;
  logic [7:0]    ledg_nxt_s;

  assign auto_s      = sw_sync_r[9];
  assign rev_s       = sw_sync_r[8];
  assign limit_s     = sw_sync_r[7:4];
  assign sel_s       = sw_sync_r[1:0];
  assign sw_unused_s = sw_sync_r[3:2];
  assign tick_s      = (presc_r == PRESC_LAST);

  assign bus.HEX0 = hex_r;
  assign bus.LEDG = ledg_r;

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sw_meta_r <= 10'd0;
      sw_sync_r <= 10'd0;
    end else begin
      sw_meta_r <= bus.SW;
      sw_sync_r <= sw_meta_r;
    end
  end

  // Next letter, prescaler and dwell count from the synchronized switches.
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = presc_r;
    dwell_nxt_s = dwell_r;
    if (!auto_s) begin
      // Manual: follow the select switches, keep both counters parked.
      state_nxt_s = state_t'(sel_s);
      presc_nxt_s = '0;
      dwell_nxt_s = 4'd0;
    end else if (!auto_r) begin
      // Mode just switched to auto: keep the letter, restart timing.
      state_nxt_s = (state_r == BLANK) ? SHOW_A : state_r;
      presc_nxt_s = '0;
      dwell_nxt_s = 4'd0;
    end else begin
      presc_nxt_s = tick_s ? '0 : (presc_r + PW'(1));
      if (tick_s && (limit_s != 4'd0)) begin
        // Compare with >= so a lowered limit takes effect on the next tick.
        if (({1'b0, dwell_r} + 5'd1) >= {1'b0, limit_s}) begin
          state_nxt_s = next_letter(state_r, rev_s);
          dwell_nxt_s = 4'd0;
        end else begin
          dwell_nxt_s = dwell_r + 4'd1;
        end
      end else begin
        // No tick, or paused with L = 0: letter and dwell hold.
        dwell_nxt_s = dwell_r;
      end
    end
  end

  assign tick_nxt_s = (presc_nxt_s == PRESC_LAST);

`ifdef SEQ_BLINK_EN
  logic blink_r;
  logic blink_nxt_s;

  // Blink phase: toggles on each tick while paused, forced off otherwise.
  always_comb begin
    blink_nxt_s = 1'b0;
    if (auto_s && auto_r && (limit_s == 4'd0)) begin
      blink_nxt_s = tick_s ? ~blink_r : blink_r;
    end else begin
      blink_nxt_s = 1'b0;
    end
  end

  // Blink phase register.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      blink_r <= 1'b0;
    end else begin
      blink_r <= blink_nxt_s;
    end
  end

  // Display pattern with the blank phase of the pause blink applied.
  always_comb begin
    if (blink_nxt_s) begin
      hex_nxt_s = 8'hFF;
    end else begin
      hex_nxt_s = seg_of(state_nxt_s);
    end
  end
`else
  // Display pattern; a pause simply holds the letter steady.
  always_comb begin
    hex_nxt_s = seg_of(state_nxt_s);
  end
`endif

  // Status LEDs: dwell count, tick pulse, auto flag and letter index.
  always_comb begin
    ledg_nxt_s = {dwell_nxt_s, tick_nxt_s, auto_s, state_nxt_s};
  end

  // Letter state machine with its counters and registered display outputs.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_r <= BLANK;
      auto_r  <= 1'b0;
      presc_r <= '0;
      dwell_r <= 4'd0;
      hex_r   <= 8'hFF;
      ledg_r  <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      auto_r  <= auto_s;
      presc_r <= presc_nxt_s;
      dwell_r <= dwell_nxt_s;
      hex_r   <= hex_nxt_s;
      ledg_r  <= ledg_nxt_s;
    end
  end

endmodule
